// File: rtl/mem_arbiter_if.sv
// Bundle of requester ports (flash, fetch, load/store) and RAM macro ports
// that mem_arbiter sits between. The arbiter uses the slave modport.
interface mem_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 11
);
  logic                    flash_en;
  logic [ADDR_WIDTH-1:0]   flash_addr;
  logic [WIDTH-1:0]        flash_data;

  logic                    if_req;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic                    if_gnt;
  logic                    if_rvalid;
  logic [WIDTH-1:0]        if_rdata;

  logic                    d_req;
  logic                    d_we;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [WIDTH-1:0]        d_wdata;
  logic [WIDTH/8-1:0]      d_be;
  logic                    d_gnt;
  logic                    d_rvalid;
  logic [WIDTH-1:0]        d_rdata;

  logic                    mem_en;
  logic                    mem_we;
  logic [WIDTH/8-1:0]      mem_be;
  logic [ADDR_WIDTH-3:0]   mem_addr;
  logic [WIDTH-1:0]        mem_wdata;
  logic [WIDTH-1:0]        mem_rdata;

  modport slave (
    input  flash_en, flash_addr, flash_data,
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output flash_en, flash_addr, flash_data,
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between flash programming, instruction fetch and
// load/store; flash always wins, data beats fetch unless fetch has starved.
module mem_arbiter #(
  parameter  int WIDTH        = 32,
  parameter  int ADDR_WIDTH   = 11,
  parameter  int STARVE_LIMIT = 4,
  localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  // Handshake: a core requester holds req (and its address/data) stable until
  // it sees gnt in the same cycle; gnt means the RAM command is issued now.
  // rvalid follows a granted read by exactly one cycle, for one cycle only.
  // Flash has no handshake: flash_en is a write that always happens.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_D  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             core_ok;
  logic             fetch_starved;
  logic             if_gnt_c;
  logic             d_gnt_c;

  always_comb begin
    core_ok       = !rst && !bus.flash_en;
    fetch_starved = bus.if_req && (starve_q == LIMIT);
    if_gnt_c      = core_ok && bus.if_req && (fetch_starved || !bus.d_req);
    d_gnt_c       = core_ok && bus.d_req && !fetch_starved;
  end

  // RAM command mux; idle defaults follow the flash port so reset-time
  // programming needs no special casing.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '1;
    bus.mem_addr  = bus.flash_addr[ADDR_WIDTH-1:2];
    bus.mem_wdata = bus.flash_data;
    if (bus.flash_en) begin
      bus.mem_en = 1'b1;
      bus.mem_we = 1'b1;
    end else if (d_gnt_c) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_we ? bus.d_be : '1;
      bus.mem_addr  = bus.d_addr[ADDR_WIDTH-1:2];
      bus.mem_wdata = bus.d_wdata;
    end else if (if_gnt_c) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.if_addr[ADDR_WIDTH-1:2];
    end
  end

  always_comb begin
    state_d  = IDLE;
    starve_d = '0;
    if (!rst) begin
      if (if_gnt_c)                  state_d = RD_IF;
      else if (d_gnt_c && !bus.d_we) state_d = RD_D;
      if (bus.if_req && !if_gnt_c)
        starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // A read in flight when reset asserts is dropped.
  always_comb begin
    bus.if_gnt    = if_gnt_c;
    bus.d_gnt     = d_gnt_c;
    bus.if_rvalid = !rst && (state_q == RD_IF);
    bus.d_rvalid  = !rst && (state_q == RD_D);
    bus.if_rdata  = bus.mem_rdata;
    bus.d_rdata   = bus.mem_rdata;
  end

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule
